delay_line_readout: RTL and testbench

- Capture side of the ring/delay-line timing sensor. Samples the N_TAPS tap outputs of a delay chain on each rising clk edge through a two-flop synchroniser.
- Converts each sample (thermometer code, bubble-tolerant) to a tap count.
- Accumulates a window of 2^LOG2_SAMPLES samples and reports average, min, max and raw sum through a valid/ack handshake.
- Sits between the delay chain and the tile's output mux / register readout.

---
 rtl/delay_line_readout_if.sv | 21 ++
 rtl/delay_line_readout.sv | 98 +++++++++
 tb/tb_delay_line_readout.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/delay_line_readout_if.sv
// delay_line_readout_if: tap inputs, measurement handshake and result bus of the delay-line readout.
interface delay_line_readout_if #(
    parameter int N_TAPS       = 16,
    parameter int LOG2_SAMPLES = 4
);
    localparam int CW = $clog2(N_TAPS + 1);
    localparam int SW = CW + LOG2_SAMPLES;
    logic [N_TAPS-1:0] taps;
    logic              start;
    logic              ack;
    logic              busy;
    logic              result_valid;
    logic [CW-1:0]     avg_code;
    logic [CW-1:0]     min_code;
    logic [CW-1:0]     max_code;
    logic [SW-1:0]     sum;
    modport master (output taps, start, ack,
                    input  busy, result_valid, avg_code, min_code, max_code, sum);
    modport slave  (input  taps, start, ack,
                    output busy, result_valid, avg_code, min_code, max_code, sum);
endinterface

// File: rtl/delay_line_readout.sv
// delay_line_readout: synchronises delay-line taps, converts them to a popcount code, and reports avg/min/max/sum over a window.
module delay_line_readout #(
    parameter int N_TAPS       = 16,
    parameter int LOG2_SAMPLES = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    delay_line_readout_if.slave bus
);
    localparam int CW = $clog2(N_TAPS + 1);
    localparam int SW = CW + LOG2_SAMPLES;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

    state_t                  state_q;
    logic [N_TAPS-1:0]       s1_q, s2_q;
    logic [LOG2_SAMPLES-1:0] cnt_q;
    logic [SW-1:0]           acc_q, acc_d, sum_q;
    logic [CW-1:0]           lo_q, lo_d, hi_q, hi_d, code;
    logic [CW-1:0]           avg_q, min_q, max_q;
    logic                    busy_q, valid_q;

    // Popcount rather than first-zero search so bubbles in the thermometer code are absorbed.
    always_comb begin
        code = '0;
        for (int i = 0; i < N_TAPS; i++) code = code + CW'(s2_q[i]);
        acc_d = acc_q + SW'(code);
        lo_d  = code < lo_q ? code : lo_q;
        hi_d  = code > hi_q ? code : hi_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s1_q <= bus.taps;
            s2_q <= s1_q;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= SETTLE;
                    busy_q  <= 1'b1;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    lo_q    <= '1;
                    hi_q    <= '0;
                end
                // Two discarded cycles let the synchroniser fill with post-start samples.
                SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q[0]) begin
                        state_q <= ACCUM;
                        cnt_q   <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    hi_q  <= hi_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        sum_q   <= acc_d;
                        avg_q   <= acc_d[SW-1:LOG2_SAMPLES];
                        min_q   <= lo_d;
                        max_q   <= hi_d;
                    end
                end
                DONE: if (bus.ack) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.avg_code     = avg_q;
    assign bus.min_code     = min_q;
    assign bus.max_code     = max_q;
    assign bus.sum          = sum_q;
endmodule

// File: tb/tb_delay_line_readout.sv
// tb_delay_line_readout: scoreboard bench; expected window statistics come from tap history via $countones.
module tb_delay_line_readout;
    localparam int N  = 16;
    localparam int L  = 4;
    localparam int NS = 1 << L;

    typedef struct {int avg; int mn; int mx; int sm;} res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_line_readout_if #(.N_TAPS(N), .LOG2_SAMPLES(L)) bus ();
    delay_line_readout #(.N_TAPS(N), .LOG2_SAMPLES(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    res_t exp_q[$];
    res_t cur, last_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare each newly presented result against the oldest expectation.
    always @(negedge clk) begin
        if (bus.busy || bus.result_valid) check("busy_valid_exclusive", int'(bus.busy & bus.result_valid), 0);
        if (bus.result_valid && !prev_v) begin
            if (exp_q.size() == 0) check("expected_queue_size", 0, 1);
            else begin
                cur = exp_q.pop_front();
                check("avg_code", bus.avg_code, cur.avg);
                check("min_code", bus.min_code, cur.mn);
                check("max_code", bus.max_code, cur.mx);
                check("sum", bus.sum, cur.sm);
            end
        end
        prev_v = bus.result_valid;
    end

    // One window: kind 0 random taps, kind 1 alternating a (odd samples) / b (even samples).
    task automatic win(input int kind, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit noisy, input int abort_k);
        int sm = 0, mn = 1 << 30, mx = 0, c;
        logic [N-1:0] t;
        bus.start = 1'b1;
        bus.taps  = N'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        for (int k = 1; k <= 18; k++) begin
            t = (kind == 0) ? N'($urandom) : ((k % 2 == 1) ? a : b);
            bus.taps  = t;
            bus.start = noisy && (k == 4 || k == 10);
            bus.ack   = noisy && (k == 6 || k == 12);
            if (k <= NS) begin
                c  = $countones(t);
                sm += c;
                mn = c < mn ? c : mn;
                mx = c > mx ? c : mx;
            end
            if (k == NS) begin
                last_e = '{sm >> L, mn, mx, sm};
                exp_q.push_back(last_e);
            end
            @(negedge clk);
            bus.start = 1'b0;
            bus.ack   = 1'b0;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_valid", bus.result_valid, 0);
                check("rst_avg", bus.avg_code, 0);
                check("rst_min", bus.min_code, 0);
                check("rst_max", bus.max_code, 0);
                check("rst_sum", bus.sum, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k == 17) begin
                check("busy_at_E17", bus.busy, 1);
                check("valid_at_E17", bus.result_valid, 0);
            end
            if (k == 18) begin
                check("busy_at_E18", bus.busy, 0);
                check("valid_at_E18", bus.result_valid, 1);
            end
        end
    endtask

    task automatic do_ack(input bit with_start);
        bus.ack   = 1'b1;
        bus.start = with_start;
        @(negedge clk);
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        check("valid_after_ack", bus.result_valid, 0);
        check("hold_sum_after_ack", bus.sum, last_e.sm);
        repeat (3) @(negedge clk);
        check("idle_after_ack", bus.busy, 0);
    endtask

    initial begin
        bus.taps  = '0;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.result_valid, 0);
        check("reset_avg", bus.avg_code, 0);
        check("reset_min", bus.min_code, 0);
        check("reset_max", bus.max_code, 0);
        check("reset_sum", bus.sum, 0);
        rst_n = 1'b1;
        @(negedge clk);
        win(1, 16'h00FF, 16'h00FF, 0, 0); do_ack(0);
        win(1, 16'h000F, 16'h0FFF, 0, 0); do_ack(0);
        win(1, 16'h00F7, 16'h00F7, 0, 0); do_ack(0);
        win(1, 16'hFFFF, 16'hFFFF, 0, 0); do_ack(0);
        win(1, 16'h00FF, 16'h00FF, 1, 0); do_ack(1);
        win(0, '0, '0, 0, 9);
        win(1, 16'h0003, 16'h0003, 0, 0); do_ack(0);
        win(0, '0, '0, 0, 0);
        repeat (50) begin
            bus.taps = N'($urandom);
            @(negedge clk);
        end
        check("hold_valid", bus.result_valid, 1);
        check("hold_avg", bus.avg_code, last_e.avg);
        check("hold_min", bus.min_code, last_e.mn);
        check("hold_max", bus.max_code, last_e.mx);
        check("hold_sum", bus.sum, last_e.sm);
        do_ack(0);
        check("hold_avg_after_ack", bus.avg_code, last_e.avg);
        check("hold_min_after_ack", bus.min_code, last_e.mn);
        check("hold_max_after_ack", bus.max_code, last_e.mx);
        for (int r = 0; r < 6; r++) begin
            win(0, '0, '0, 0, 0);
            do_ack(r % 2 == 1);
        end
        repeat (3) @(negedge clk);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
